// File: rtl/beam_bank.sv
// Bank of NUM_BEAMS projectile slots: launch on shoot, climb STEP rows per move tick, retire on hit or top.
// Optional post-shot lockout guarded by macro BEAM_COOLDOWN_EN (undefined: acceptance depends only on full).
module beam_bank #(
   parameter int NUM_BEAMS = 4,
   parameter int X_W       = 8,
   parameter int Y_W       = 7,
   parameter int Y_START   = 112,
   parameter int STEP      = 4,
   parameter int TICK_DIV  = 833334,
   parameter int COOLDOWN  = 8
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     shoot,
   input  logic [X_W-1:0]           x_in,
   input  logic [NUM_BEAMS-1:0]     hit,
   output logic [NUM_BEAMS-1:0]     active,
   output logic [NUM_BEAMS*X_W-1:0] x_bus,
   output logic [NUM_BEAMS*Y_W-1:0] y_bus,
   output logic                     full,
   output logic                     fire_ack
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FLY    = 2'd1,
      S_RETIRE = 2'd2
   } slot_state_e;

   slot_state_e          state_q [NUM_BEAMS];
   slot_state_e          state_d [NUM_BEAMS];
   logic [X_W-1:0]       x_q     [NUM_BEAMS];
   logic [X_W-1:0]       x_d     [NUM_BEAMS];
   logic [Y_W-1:0]       y_q     [NUM_BEAMS];
   logic [Y_W-1:0]       y_d     [NUM_BEAMS];

   logic [CNT_W-1:0]     tick_cnt_q, tick_cnt_d;
   logic                 fire_ack_q, fire_ack_d;
   logic                 move_tick;
   logic                 lock_clear;
   logic                 accept;
   logic [NUM_BEAMS-1:0] idle_vec;
   logic [NUM_BEAMS-1:0] grant;

   // Shared move-tick divider
   assign move_tick = (tick_cnt_q == CNT_W'(TICK_DIV - 1));

   always_comb begin
      tick_cnt_d = tick_cnt_q + CNT_W'(1);
      if (move_tick) begin
         tick_cnt_d = '0;
      end
   end

   always_comb begin
      idle_vec = '0;
      for (int i = 0; i < NUM_BEAMS; i++) begin
         idle_vec[i] = (state_q[i] == S_IDLE);
      end
   end

   // A slot leaving RETIRE this edge is not yet IDLE, so it cannot be granted until next cycle.
   assign full   = ~|idle_vec;
   assign grant  = idle_vec & (~idle_vec + NUM_BEAMS'(1));
   assign accept = shoot & ~full & lock_clear;

`ifdef BEAM_COOLDOWN_EN
   localparam int LOCK_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

   logic [LOCK_W-1:0] lock_q, lock_d;

   assign lock_clear = (lock_q == '0);

   always_comb begin
      lock_d = lock_q;
      if (accept) begin
         lock_d = LOCK_W'(COOLDOWN);
      end else if (!lock_clear) begin
         lock_d = lock_q - LOCK_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         lock_q <= '0;
      end else begin
         lock_q <= lock_d;
      end
   end
`else
   assign lock_clear = 1'b1;
`endif

   // Per-slot FSMs: a hit outranks a move; a slot below STEP retires with y untouched.
   always_comb begin
      for (int i = 0; i < NUM_BEAMS; i++) begin
         state_d[i] = state_q[i];
         x_d[i]     = x_q[i];
         y_d[i]     = y_q[i];
         unique case (state_q[i])
            S_IDLE: begin
               if (accept && grant[i]) begin
                  state_d[i] = S_FLY;
                  x_d[i]     = x_in;
                  y_d[i]     = Y_W'(Y_START);
               end
            end
            S_FLY: begin
               if (hit[i]) begin
                  state_d[i] = S_RETIRE;
               end else if (move_tick) begin
                  if (y_q[i] >= Y_W'(STEP)) begin
                     y_d[i] = y_q[i] - Y_W'(STEP);
                  end else begin
                     state_d[i] = S_RETIRE;
                  end
               end
            end
            S_RETIRE: begin
               state_d[i] = S_IDLE;
            end
            default: begin
               state_d[i] = S_IDLE;
            end
         endcase
      end
   end

   assign fire_ack_d = accept;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         tick_cnt_q <= '0;
         fire_ack_q <= 1'b0;
         for (int i = 0; i < NUM_BEAMS; i++) begin
            state_q[i] <= S_IDLE;
            x_q[i]     <= '0;
            y_q[i]     <= Y_W'(Y_START);
         end
      end else begin
         tick_cnt_q <= tick_cnt_d;
         fire_ack_q <= fire_ack_d;
         for (int i = 0; i < NUM_BEAMS; i++) begin
            state_q[i] <= state_d[i];
            x_q[i]     <= x_d[i];
            y_q[i]     <= y_d[i];
         end
      end
   end

   always_comb begin
      active = '0;
      x_bus  = '0;
      y_bus  = '0;
      for (int i = 0; i < NUM_BEAMS; i++) begin
         active[i]             = (state_q[i] == S_FLY);
         x_bus[i*X_W +: X_W]   = x_q[i];
         y_bus[i*Y_W +: Y_W]   = y_q[i];
      end
   end

   assign fire_ack = fire_ack_q;

endmodule

// File: tb/tb_beam_bank.sv
// Randomized and directed checks of beam_bank against a slot-list reference model.
module tb_beam_bank;
   localparam int NB = 4;
   localparam int XW = 8;
   localparam int YW = 7;
   localparam int YS = 112;
   localparam int ST = 4;
   localparam int TD = 4;
   localparam int CD = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             resetn, shoot;
   logic [XW-1:0]    x_in;
   logic [NB-1:0]    hit, active;
   logic [NB*XW-1:0] x_bus;
   logic [NB*YW-1:0] y_bus;
   logic             full, fire_ack;

   beam_bank #(
      .NUM_BEAMS(NB), .X_W(XW), .Y_W(YW), .Y_START(YS),
      .STEP(ST), .TICK_DIV(TD), .COOLDOWN(CD)
   ) dut (
      .clk(clk), .resetn(resetn), .shoot(shoot), .x_in(x_in), .hit(hit),
      .active(active), .x_bus(x_bus), .y_bus(y_bus), .full(full), .fire_ack(fire_ack)
   );

   // Reference model: each slot is flying, retiring (one cycle) or free.
   bit m_fly [NB];
   bit m_ret [NB];
   int m_x   [NB];
   int m_y   [NB];
   int m_cyc;
   int m_lock;
   bit m_ack;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int slot_x(input int i);
      return int'(x_bus[i*XW +: XW]);
   endfunction

   function automatic int slot_y(input int i);
      return int'(y_bus[i*YW +: YW]);
   endfunction

   task automatic model_step(input bit sh, input int xv, input logic [NB-1:0] h, input bit rn);
      bit tick, any_free, accept;
      int pick;
      if (!rn) begin
         for (int i = 0; i < NB; i++) begin
            m_fly[i] = 0; m_ret[i] = 0; m_x[i] = 0; m_y[i] = YS;
         end
         m_cyc = 0; m_lock = 0; m_ack = 0;
         return;
      end
      tick = ((m_cyc % TD) == TD - 1);
      pick = -1;
      for (int i = NB - 1; i >= 0; i--) begin
         if (!m_fly[i] && !m_ret[i]) pick = i;
      end
      any_free = (pick >= 0);
`ifdef BEAM_COOLDOWN_EN
      accept = sh && any_free && (m_lock == 0);
      m_lock = accept ? CD : ((m_lock > 0) ? m_lock - 1 : 0);
`else
      accept = sh && any_free;
`endif
      for (int i = 0; i < NB; i++) begin
         if (m_ret[i]) begin
            m_ret[i] = 0;
         end else if (m_fly[i]) begin
            if (h[i]) begin
               m_fly[i] = 0; m_ret[i] = 1;
            end else if (tick) begin
               if (m_y[i] >= ST) m_y[i] = m_y[i] - ST;
               else begin m_fly[i] = 0; m_ret[i] = 1; end
            end
         end else if (accept && i == pick) begin
            m_fly[i] = 1; m_x[i] = xv; m_y[i] = YS;
         end
      end
      m_ack = accept;
      m_cyc++;
   endtask

   task automatic check_model();
      logic [NB-1:0]    ea;
      logic [NB*XW-1:0] ex;
      logic [NB*YW-1:0] ey;
      logic             ef;
      ef = 1'b1;
      for (int i = 0; i < NB; i++) begin
         ea[i] = m_fly[i];
         ex[i*XW +: XW] = XW'(m_x[i]);
         ey[i*YW +: YW] = YW'(m_y[i]);
         if (!m_fly[i] && !m_ret[i]) ef = 1'b0;
      end
      check("mdl_active", 64'(active), 64'(ea));
      check("mdl_x_bus", 64'(x_bus), 64'(ex));
      check("mdl_y_bus", 64'(y_bus), 64'(ey));
      check("mdl_full", 64'(full), 64'(ef));
      check("mdl_fire_ack", 64'(fire_ack), 64'(m_ack));
   endtask

   task automatic cycle(input bit sh, input logic [XW-1:0] xv, input logic [NB-1:0] h, input bit rn);
      shoot = sh; x_in = xv; hit = h; resetn = rn;
      @(posedge clk);
      model_step(sh, int'(xv), h, rn);
      @(negedge clk);
      check_model();
   endtask

   task automatic do_reset();
      cycle(0, '0, '0, 0);
      cycle(0, '0, '0, 0);
   endtask

   initial begin
      int seen, last, guard, y0p, y2p, mask;
      bit found;
      logic [3:0] exp_act [5];
      bit         exp_ack [5];
      shoot = 0; x_in = '0; hit = '0; resetn = 0;
      @(negedge clk);

      // Reset state
      do_reset();
      check("rst_active", 64'(active), 64'h0);
      check("rst_full", 64'(full), 64'h0);
      check("rst_ack", 64'(fire_ack), 64'h0);
      check("rst_y0", 64'(slot_y(0)), 64'd112);
      check("rst_x0", 64'(slot_x(0)), 64'd0);

      // First shot
      cycle(1, 8'd50, '0, 1);
      check("shot_active", 64'(active), 64'h1);
      check("shot_x0", 64'(slot_x(0)), 64'd50);
      check("shot_y0", 64'(slot_y(0)), 64'd112);
      check("shot_ack", 64'(fire_ack), 64'd1);
      cycle(0, '0, '0, 1);
      check("ack_pulse", 64'(fire_ack), 64'd0);

      // Full flight to the top and retirement
      seen = 1; last = slot_y(0); guard = 0;
      while (active[0] && guard < 200) begin
         cycle(0, '0, '0, 1);
         if (active[0] && slot_y(0) != last) begin
            seen++; last = slot_y(0);
         end
         guard++;
      end
      check("flight_timeout", 64'(guard < 200), 64'd1);
      check("flight_rows", 64'(seen), 64'd29);
      check("flight_end_y0", 64'(slot_y(0)), 64'd0);
      cycle(0, '0, '0, 1);
      check("hold_y0", 64'(slot_y(0)), 64'd0);

`ifndef BEAM_COOLDOWN_EN
      // Hold shoot five cycles: four allocations, fifth rejected
      do_reset();
      exp_act = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111};
      exp_ack = '{1, 1, 1, 1, 0};
      for (int k = 0; k < 5; k++) begin
         cycle(1, XW'(10 + k), '0, 1);
         check("hold5_active", 64'(active), 64'(exp_act[k]));
         check("hold5_ack", 64'(fire_ack), 64'(exp_ack[k]));
      end
      check("hold5_full", 64'(full), 64'd1);
      check("hold5_x3", 64'(slot_x(3)), 64'd13);
`else
      // Hold shoot twenty cycles under lockout
      do_reset();
      mask = 0;
      for (int k = 0; k < 20; k++) begin
         cycle(1, XW'(k), '0, 1);
         if (fire_ack) mask |= (1 << k);
      end
      check("cool_accepts", 64'(mask), 64'((1 << 0) | (1 << 9) | (1 << 18)));
`endif

      // Hit at y=60 on a move tick
      do_reset();
      cycle(1, 8'd1, '0, 1);
      for (int k = 0; k < CD + 1; k++) cycle(0, '0, '0, 1);
      cycle(1, 8'd2, '0, 1);
      for (int k = 0; k < CD + 1; k++) cycle(0, '0, '0, 1);
      cycle(1, 8'd3, '0, 1);
      found = 0; guard = 0;
      while (!found && guard < 400) begin
         if (m_fly[1] && m_y[1] == 60 && (m_cyc % TD) == TD - 1) found = 1;
         else cycle(0, '0, '0, 1);
         guard++;
      end
      check("hit_setup_timeout", 64'(found), 64'd1);
      check("hit_pre_y1", 64'(slot_y(1)), 64'd60);
      y0p = slot_y(0); y2p = slot_y(2);
      cycle(0, '0, 4'b0010, 1);
      check("hit_active1", 64'(active[1]), 64'd0);
      check("hit_y1", 64'(slot_y(1)), 64'd60);
      check("hit_y0_moves", 64'(slot_y(0)), 64'(y0p - ST));
      check("hit_y2_moves", 64'(slot_y(2)), 64'(y2p - ST));
      cycle(0, '0, 4'b0010, 1);
      check("hit_y1_hold", 64'(slot_y(1)), 64'd60);

      // Reset mid-flight
      do_reset();
      for (int k = 0; k < 3; k++) begin
         cycle(1, XW'(20 + k), '0, 1);
         for (int j = 0; j < CD + 1; j++) cycle(0, '0, '0, 1);
      end
      cycle(0, '0, '0, 0);
      check("mrst_active", 64'(active), 64'h0);
      for (int i = 0; i < NB; i++) check("mrst_y", 64'(slot_y(i)), 64'd112);
      cycle(1, 8'd77, '0, 1);
      check("mrst_shot_active", 64'(active), 64'h1);
      check("mrst_shot_x0", 64'(slot_x(0)), 64'd77);

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         logic [NB-1:0] h;
         for (int i = 0; i < NB; i++) h[i] = ($urandom_range(0, 11) == 0);
         cycle(bit'($urandom_range(0, 1)), XW'($urandom),
               h, ($urandom_range(0, 299) != 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/beam_bank.md
BEAM_BANK -- requirements
Module: beam_bank

Interface
REQ-001 Parameter NUM_BEAMS, default 4, SHALL set the number of independent beam slots (1..16).
REQ-002 Parameter X_W, default 8, SHALL set the x coordinate width.
REQ-003 Parameter Y_W, default 7, SHALL set the y coordinate width.
REQ-004 Parameter Y_START, default 112, SHALL set the launch row for every new beam.
REQ-005 Parameter STEP, default 4, SHALL set the rows moved upward per move tick.
REQ-006 Parameter TICK_DIV, default 833334, SHALL set the clk cycles per move tick (>=1).
REQ-007 Parameter COOLDOWN, default 8, SHALL set the post-shot lockout cycles (used only per REQ-030).
REQ-008 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-009 resetn  input  1  reset, synchronous, active-low.
REQ-010 shoot  input  1  level request to launch a beam at x_in.
REQ-011 x_in  input  X_W  launch column.
REQ-012 hit  input  NUM_BEAMS  per-slot collision; bit i retires slot i.
REQ-013 active  output  NUM_BEAMS  bit i high while slot i is flying.
REQ-014 x_bus  output  NUM_BEAMS*X_W  slot i x at bits [i*X_W +: X_W].
REQ-015 y_bus  output  NUM_BEAMS*Y_W  slot i y at bits [i*Y_W +: Y_W].
REQ-016 full  output  1  high when no slot is IDLE.
REQ-017 fire_ack  output  1  one-cycle registered pulse the cycle after a shot is accepted.

Function
REQ-018 Each slot SHALL run its own FSM: IDLE -> FLY -> RETIRE -> IDLE.
REQ-019 A shot SHALL be accepted on an edge where shoot=1, full=0 and (per REQ-030) no lockout is active.
REQ-020 On acceptance, the lowest-index IDLE slot SHALL capture x_in, load y=Y_START and enter FLY; exactly one slot per cycle.
REQ-021 A shared tick counter SHALL count 0..TICK_DIV-1 and assert move_tick for one cycle when at TICK_DIV-1, wrapping to 0.
REQ-022 On move_tick, every FLY slot with y>=STEP SHALL update y <= y-STEP; a slot launched on that same edge SHALL NOT move.
REQ-023 On move_tick, a FLY slot with y<STEP SHALL go to RETIRE without updating y; y SHALL never wrap below 0.
REQ-024 hit[i]=1 while slot i is in FLY SHALL send it to RETIRE on that edge, taking priority over a simultaneous move; hit[i] in IDLE or RETIRE SHALL be ignored.
REQ-025 RETIRE SHALL last exactly one cycle, then IDLE; x and y SHALL hold their last values in RETIRE and IDLE.
REQ-026 active[i] SHALL be 1 only in FLY; full SHALL be computed combinationally from slot states.
REQ-027 A slot entering IDLE on the same edge that a shot arrives SHALL NOT be allocated until the next cycle.

Reset
REQ-028 While resetn=0 at an edge, all slots SHALL go to IDLE with x=0, y=Y_START, and active=0, fire_ack=0, tick counter=0, lockout counter=0; full SHALL read 0.
REQ-029 Reset asserted mid-flight SHALL discard all beams with no RETIRE cycle.

Configuration
REQ-030 With BEAM_COOLDOWN_EN defined, a lockout counter SHALL load COOLDOWN on each acceptance and decrement to 0; shots SHALL be rejected while it is nonzero. Without the macro, there SHALL be no lockout counter, and acceptance depends only on full.

Verification (TICK_DIV=4, NUM_BEAMS=4, Y_START=112, STEP=4, COOLDOWN=8)
REQ-031 Reset, then shoot=1 for 1 cycle with x_in=50 -> next cycle active=0001, x0=50, y0=112, fire_ack=1 for 1 cycle.
REQ-032 Single beam, no hits -> y0 steps 112,108,...,0 once per 4 cycles; the next tick gives RETIRE, then active=0; y0 holds at 0.
REQ-033 Macro undefined, shoot held 5 cycles -> slots 0..3 allocated on consecutive cycles, full=1, and the 5th shot is rejected with no fire_ack.
REQ-034 hit[1] asserted on the same edge as move_tick while slot 1 is at y=60 -> slot 1 retires with y1=60, and the other slots move normally.
REQ-035 Macro defined, shoot held 20 cycles -> shots are accepted at cycles 0, 9 and 18 only.
REQ-036 resetn=0 for 1 cycle while 3 beams are flying -> active=0, y=112 in all slots, and a shot on the following cycle is accepted into slot 0.
